// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
//
// Request front-end and service controller placed around an external 4-input
// priority encoder (D3 highest priority, D0 lowest).
//
// Raw asynchronous request lines are synchronised, and their rising edges are
// captured into sticky pending bits. The unmasked pending bits drive the
// encoder inputs D0..D3. The encoder result {x,y} (valid z) is captured into a
// valid/ack handshake that presents one interrupt ID at a time.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (released synchronously)
//   req_in     in   [3:0] raw asynchronous request lines, bit i -> Di
//   mask       in   [3:0] synchronous mask, 1 blocks channel i from encoder
//   D0..D3     out  pending[i] & ~mask[i], to the encoder inputs
//   x, y       in   encoder index {MSB, LSB}
//   z          in   encoder valid (any Di high)
//   irq_valid  out  interrupt presented to the consumer
//   irq_id     out  [1:0] index of the presented interrupt
//   irq_ack    in   consumer acknowledge, honoured only while presenting
//   pending    out  [3:0] raw (unmasked) pending register
//   svc_count  out  [CNT_W-1:0] acknowledged-interrupt count, wraps silently
// -----------------------------------------------------------------------------
module irq_pending_ctrl #(
  parameter int SYNC_STAGES = 2,  // legal range 2..4
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_in,
  input  logic [3:0]       mask,
  output logic             D0,
  output logic             D1,
  output logic             D2,
  output logic             D3,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             irq_valid,
  output logic [1:0]       irq_id,
  input  logic             irq_ack,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] svc_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers: one SYNC_STAGES-deep chain per request line.
  // ---------------------------------------------------------------------------
  logic [3:0] sync_out;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          chain_q <= '0;
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], req_in[gi]};
        end
      end

      assign sync_out[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Edge detection into sticky pending bits.
  // ---------------------------------------------------------------------------
  logic [3:0] hist_q;
  logic [3:0] rise;
  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] clr;

  state_t           state_q;
  logic             irq_valid_q;
  logic [1:0]       irq_id_q;
  logic [CNT_W-1:0] svc_count_q;
  logic [CNT_W-1:0] svc_count_d;

  assign rise = sync_out & ~hist_q;

  // Clear the presented channel on an accepted ack.
  always_comb begin
    clr = 4'b0000;
    if ((state_q == S_WAIT) && irq_ack) begin
      clr[irq_id_q] = 1'b1;
    end
  end

  // A fresh edge arriving on the ack edge must survive the clear, so the set
  // term is OR-ed in after the clear is applied.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= 4'b0000;
      pending_q <= 4'b0000;
    end else begin
      hist_q    <= sync_out;
      pending_q <= pending_d;
    end
  end

  // Encoder inputs are purely combinational so the encoder sees a cleared bit
  // in the very next cycle (the GAP state).
  assign D0 = pending_q[0] & ~mask[0];
  assign D1 = pending_q[1] & ~mask[1];
  assign D2 = pending_q[2] & ~mask[2];
  assign D3 = pending_q[3] & ~mask[3];

  // ---------------------------------------------------------------------------
  // Service FSM with registered handshake outputs.
  // ---------------------------------------------------------------------------
  assign svc_count_d = svc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= 2'b00;
      svc_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (z) begin
            irq_id_q    <= {x, y};
            irq_valid_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ID and valid are frozen here; only the ack can move us on.
          if (irq_ack) begin
            irq_valid_q <= 1'b0;
            svc_count_q <= svc_count_d;
            state_q     <= S_GAP;
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          irq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign svc_count = svc_count_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios plus a randomised phase,
// all checked against a cycle-level reference model of the request rules.
module tb_irq_pending_ctrl;

  localparam int S     = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req_in = 4'b0000;
  logic [3:0]       mask = 4'b0000;
  logic             D0, D1, D2, D3;
  logic             x, y, z;
  logic             irq_valid;
  logic [1:0]       irq_id;
  logic             irq_ack = 1'b0;
  logic [3:0]       pending;
  logic [CNT_W-1:0] svc_count;

  irq_pending_ctrl #(.SYNC_STAGES(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .x(x), .y(y), .z(z),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
    .pending(pending), .svc_count(svc_count)
  );

  always #5 clk = ~clk;

  // External priority encoder: D3 highest.
  always_comb begin
    z = D0 | D1 | D2 | D3;
    if (D3)      {x, y} = 2'd3;
    else if (D2) {x, y} = 2'd2;
    else if (D1) {x, y} = 2'd1;
    else         {x, y} = 2'd0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_hist[$];   // req samples, front = most recent edge
  logic [3:0] m_pend;
  logic       m_valid;
  logic [1:0] m_id;
  logic       m_block;     // one forced idle edge after an ack
  int         m_cnt;
  logic [1:0] pres[$];     // IDs seen rising on the DUT

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= S; i++) m_hist.push_back(4'b0000);
    m_pend = 4'b0000; m_valid = 1'b0; m_id = 2'd0; m_block = 1'b0; m_cnt = 0;
  endtask

  function automatic logic [1:0] highest(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_edge();
    logic [3:0] rise, elig, clear;
    rise  = m_hist[S-1] & ~m_hist[S];
    elig  = m_pend & ~mask;
    clear = 4'b0000;
    if (m_valid) begin
      if (irq_ack) begin
        clear   = 4'b0001 << m_id;
        m_valid = 1'b0;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        m_block = 1'b1;
      end
    end else if (m_block) begin
      m_block = 1'b0;
    end else if (elig != 4'b0000) begin
      m_valid = 1'b1;
      m_id    = highest(elig);
    end
    m_pend = (m_pend & ~clear) | rise;
    m_hist.push_front(req_in);
    void'(m_hist.pop_back());
  endtask

  task automatic step();
    logic was_valid;
    was_valid = irq_valid;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(irq_valid), 32'(m_valid));
    chk("id", 32'(irq_id), 32'(m_id));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("svc_count", 32'(svc_count), 32'(m_cnt));
    chk("D", 32'({D3, D2, D1, D0}), 32'(m_pend & ~mask));
    if (irq_valid && !was_valid) pres.push_back(irq_id);
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !irq_valid; i++) step();
    chk("wait_valid", 32'(irq_valid), 32'd1);
  endtask

  task automatic serve(input int delay);
    wait_valid(40);
    repeat (delay) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(irq_valid), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_count", 32'(svc_count), 32'd0);
    chk("rst_D", 32'({D3, D2, D1, D0}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk); #1;

    // 1: reset with all requests held high
    req_in = 4'b1111;
    do_reset();
    step(); step();
    chk("t1_pend_e1", 32'(pending), 32'd0);
    step();
    chk("t1_pend_e2", 32'(pending), 32'hF);
    step();
    chk("t1_valid_e3", 32'(irq_valid), 32'd1);
    chk("t1_id_e3", 32'(irq_id), 32'd3);
    req_in = 4'b0000;
    repeat (4) serve(int'($urandom_range(0, 3)));
    step(); step();

    // 2: pending 0101, each ack after 2 cycles
    pres = {};
    req_in = 4'b0101; step(); req_in = 4'b0000;
    wait_valid(20);
    step(); step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t2_low_n", 32'(irq_valid), 32'd0);
    step();
    chk("t2_low_n1", 32'(irq_valid), 32'd0);
    step();
    chk("t2_high_n2", 32'(irq_valid), 32'd1);
    chk("t2_id2", 32'(irq_id), 32'd0);
    step(); step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t2_npres", 32'(pres.size()), 32'd2);
    if (pres.size() == 2) begin
      chk("t2_first", 32'(pres[0]), 32'd2);
      chk("t2_second", 32'(pres[1]), 32'd0);
    end
    chk("t2_count", 32'(svc_count), 32'd6);
    chk("t2_pend", 32'(pending), 32'd0);
    step(); step();

    // 3: channel 3 masked while channel 1 is served
    pres = {};
    mask = 4'b1000;
    req_in = 4'b1010; step(); req_in = 4'b0000;
    serve(1);
    repeat (5) step();
    chk("t3_held", 32'(pending), 32'h8);
    chk("t3_quiet", 32'(irq_valid), 32'd0);
    mask = 4'b0000;
    serve(0);
    chk("t3_npres", 32'(pres.size()), 32'd2);
    if (pres.size() == 2) begin
      chk("t3_first", 32'(pres[0]), 32'd1);
      chk("t3_second", 32'(pres[1]), 32'd3);
    end
    step(); step();

    // 4: higher request during WAIT does not preempt
    pres = {};
    req_in = 4'b0001; step(); req_in = 4'b0000;
    wait_valid(20);
    req_in = 4'b1000; step(); req_in = 4'b0000;
    repeat (4) begin
      step();
      chk("t4_stable", 32'(irq_id), 32'd0);
    end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    serve(0);
    chk("t4_npres", 32'(pres.size()), 32'd2);
    if (pres.size() == 2) chk("t4_next", 32'(pres[1]), 32'd3);
    step(); step();

    // 5: re-edge on channel 2 lands on its own ack edge
    pres = {};
    req_in = 4'b0100; step(); req_in = 4'b0000;
    wait_valid(20);
    step();
    req_in = 4'b0100; step();
    req_in = 4'b0000; step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("t5_setwins", 32'(pending[2]), 32'd1);
    chk("t5_dropped", 32'(irq_valid), 32'd0);
    serve(0);
    chk("t5_npres", 32'(pres.size()), 32'd2);
    if (pres.size() == 2) chk("t5_again", 32'(pres[1]), 32'd2);
    step(); step();

    // random phase
    for (int i = 0; i < 400; i++) begin
      req_in  = 4'($urandom_range(0, 15));
      if ((i % 8) == 0) mask = 4'($urandom_range(0, 15));
      irq_ack = ($urandom_range(0, 2) == 0);
      step();
    end
    req_in = 4'b0000; mask = 4'b0000; irq_ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      irq_ack = irq_valid;
      step();
    end
    irq_ack = 1'b0;

    // 6: counter wrap, then reset mid-WAIT
    do_reset();
    for (int r = 0; r < 256; r++) begin
      req_in = 4'b0010; step(); req_in = 4'b0000;
      serve(0);
    end
    chk("t6_wrap", 32'(svc_count), 32'd0);
    for (int r = 0; r < 3; r++) begin
      req_in = 4'b0010; step(); req_in = 4'b0000;
      serve(0);
    end
    chk("t6_count3", 32'(svc_count), 32'd3);
    req_in = 4'b0001; step(); req_in = 4'b0000;
    wait_valid(20);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(irq_valid), 32'd0);
    chk("t6_rst_count", 32'(svc_count), 32'd0);
    chk("t6_rst_pend", 32'(pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
